// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot-stage program loader.
package prog_loader_pkg;
    localparam int          ADDR_W_DEF   = 8;
    localparam int          DATA_W_DEF   = 8;
    localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
    localparam int          MAX_LEN      = (1 << ADDR_W_DEF) - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and status outputs of the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W-1:0] byte_count;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_we,
        input  cpu_run, load_done, load_err, byte_count
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_we,
        output cpu_run, load_done, load_err, byte_count
    );
endinterface

// File: rtl/prog_loader_csum.sv
// Modular running-sum accumulator with a combinational compare against an expected value.
module prog_loader_csum #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] cmp_i,
    output logic         match_o
);
    logic [W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) sum_q <= '0;
        else if (en_i)    sum_q <= sum_q + data_i;
    end

    assign match_o = (sum_q == cmp_i);
endmodule

// File: rtl/prog_loader.sv
// Frame parser: header, length, payload written to imem from address 0, then checksum.
// A matching checksum releases the CPU; the loader then stops accepting bytes until reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input logic           clk,
    input logic           rst,
    prog_loader_if.slave  bus
);
    state_e            state_q;
    logic [ADDR_W-1:0] rem_q, byte_count_q, mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              in_ready_q, mem_we_q, cpu_run_q, load_done_q, load_err_q;
    logic              xfer, is_hdr, sum_ok;

    assign xfer   = bus.in_valid && in_ready_q;
    assign is_hdr = (bus.in_data == HDR_BYTE);

    prog_loader_csum #(.W(DATA_W)) u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (xfer && is_hdr && (state_q == IDLE || state_q == ERR)),
        .en_i    (xfer && state_q == DATA),
        .data_i  (bus.in_data),
        .cmp_i   (bus.in_data),
        .match_o (sum_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            byte_count_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            cpu_run_q    <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                // Header bytes inside the payload never reach this branch,
                // so they are treated as data.
                IDLE, ERR: if (xfer && is_hdr) begin
                    state_q      <= LEN;
                    load_err_q   <= 1'b0;
                    byte_count_q <= '0;
                end
                LEN: if (xfer) begin
                    rem_q <= ADDR_W'(bus.in_data);
                    if (bus.in_data == '0) begin
                        state_q    <= ERR;
                        load_err_q <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (xfer) begin
                    mem_addr_q   <= byte_count_q;
                    mem_data_q   <= bus.in_data;
                    mem_we_q     <= 1'b1;
                    byte_count_q <= byte_count_q + 1'b1;
                    rem_q        <= rem_q - 1'b1;
                    if (rem_q == ADDR_W'(1)) state_q <= CHK;
                end
                CHK: if (xfer) begin
                    if (sum_ok) begin
                        state_q     <= DONE;
                        load_done_q <= 1'b1;
                        cpu_run_q   <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end else begin
                        state_q    <= ERR;
                        load_err_q <= 1'b1;
                    end
                end
                DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
    assign bus.byte_count = byte_count_q;
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 8-bit accumulator processor.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into instruction memory starting at address 0.
- Verifies a checksum over the payload; on success, releases the processor by asserting cpu_run.
- While it is loading, it owns the memory write port and the processor is held.

Parameters:
- ADDR_W, 8, memory address width; maximum payload is 2^ADDR_W-1 bytes.
- DATA_W, 8, byte width of the stream and memory words.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; everything is updated on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  DATA_W  upstream byte.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid&&in_ready at posedge.
- mem_addr  output  ADDR_W  instruction memory write address.
- mem_data  output  DATA_W  instruction memory write data.
- mem_we  output  1  one-cycle write strobe.
- cpu_run  output  1  processor release; level signal.
- load_done  output  1  frame accepted, checksum matched; sticky.
- load_err  output  1  bad length or bad checksum; sticky until the next header.
- byte_count  output  ADDR_W  payload bytes written in the current frame.

Behaviour:
- Reset (synchronous, active-high; sampled on posedge clk): state=IDLE.
  - in_ready=1, mem_we=0, mem_addr=0, mem_data=0.
  - cpu_run=0, load_done=0, load_err=0, byte_count=0.
  - Memory contents are not cleared.
  - Reset mid-frame aborts immediately, with the same values.
- States: IDLE, LEN, DATA, CHK, DONE, ERR. All outputs are registered.
- IDLE:
  - Transferred byte == HDR_BYTE -> LEN; clear load_err, byte_count and the running sum.
  - Any other byte is consumed and discarded.
- LEN:
  - Transferred byte N is stored as the remaining count.
  - N==0 -> ERR. Otherwise -> DATA.
- DATA: each transfer drives a write on the next cycle:
  - mem_addr=byte_count, mem_data=in_data, mem_we=1 for exactly one cycle.
  - byte_count increments; sum = sum + in_data (mod 256).
  - After the Nth byte -> CHK.
  - Back-to-back transfers produce back-to-back writes, one per cycle.
- CHK:
  - Transferred byte == sum -> DONE; load_done=1 and cpu_run=1 in the cycle after the transfer.
  - Mismatch -> ERR; load_err=1 in the cycle after the transfer.
- DONE:
  - in_ready=0; cpu_run, load_done and byte_count hold until rst.
  - No further writes.
- ERR:
  - in_ready=1; cpu_run=0.
  - A HDR_BYTE transfer restarts the frame (-> LEN, load_err clears); other bytes are discarded.
  - Already-written memory is left as is.
- Handshake rules:
  - in_ready is 1 in every state except DONE.
  - A byte is never dropped while in_valid=1 and in_ready=1.
  - in_valid low in any state: hold state, mem_we=0.
- Boundary conditions:
  - N=255 writes addresses 0..254.
  - byte_count never wraps within a frame.
  - A HDR_BYTE value inside the payload or checksum is treated as data, not as a restart.
- Latency: a byte transferred at edge k is written to memory at edge k+1.

Decomposition:
- Shared package prog_loader_pkg holds:
  - the state encoding (3-bit localparams IDLE..ERR);
  - the HDR_BYTE default;
  - the MAX_LEN constant.
- One sub-module is natural: prog_loader_csum.
  - Function: 8-bit running-sum accumulator with clear/enable and an equality compare output.
  - The FSM, counter and write-port logic stay in prog_loader.

Test Plan:
- Frame A5 03 01 02 03 06, in_valid held high:
  - writes mem[0]=01, mem[1]=02, mem[2]=03 on consecutive cycles;
  - cpu_run=1 one cycle after the 06 transfer; in_ready=0 afterwards.
- Frame A5 02 10 20 31 (bad checksum, expected 30):
  - load_err=1, cpu_run=0, byte_count=2;
  - then A5 01 7F 7F -> load_done=1, load_err=0, mem[0]=7F.
- Frame A5 00:
  - immediate ERR, no mem_we pulses;
  - leading garbage 11 22 before A5 is discarded with no writes.
- in_valid toggling every other cycle during A5 04 A5 A5 A5 A5 94:
  - the four A5 payload bytes are written to addresses 0..3, not treated as headers;
  - checksum 94 accepted -> DONE.
- rst asserted for one cycle after 2 payload bytes of a 5-byte frame:
  - next cycle state=IDLE, byte_count=0, cpu_run=0;
  - a fresh full frame then loads correctly.
- Length 255 frame of incrementing bytes 00..FE with correct sum (8'h81):
  - final write at address FE; byte_count=255; cpu_run=1.
